// File: rtl/memory_request_arbiter_if.sv
// Bundle of the datapath request port and the shared RAM port seen by the arbiter.
// The slave modport is the arbiter; master is the datapath/RAM environment.
interface memory_request_arbiter_if #(
    parameter int CNT_W = 32
);
    logic             iREN;
    logic [31:0]      iaddr;
    logic             dREN;
    logic             dWEN;
    logic [31:0]      daddr;
    logic [31:0]      dstore;
    logic             ihit;
    logic [31:0]      iload;
    logic             dhit;
    logic [31:0]      dload;
    logic             ramREN;
    logic             ramWEN;
    logic [31:0]      ramaddr;
    logic [31:0]      ramstore;
    logic [31:0]      ramload;
    logic             ramACK;
    logic             timeout;
    logic             req_err;
    logic [CNT_W-1:0] ifetch_cnt;
    logic [CNT_W-1:0] dacc_cnt;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramACK,
        output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore,
        output timeout, req_err, ifetch_cnt, dacc_cnt
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramACK,
        input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore,
        input  timeout, req_err, ifetch_cnt, dacc_cnt
    );
endinterface

// File: rtl/memory_request_arbiter.sv
// Arbitrates instruction and data requests onto a single RAM port with a
// wait-state watchdog, sticky error flags and completion counters.
module memory_request_arbiter #(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 32
) (
    input  logic                      CLK,
    input  logic                      nRST,
    memory_request_arbiter_if.slave   bus
);
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_INSTR = 2'd2
    } state_t;

    state_t             state_q;
    logic               last_data_q;
    logic               op_wr_q;
    logic               ram_ren_q;
    logic               ram_wen_q;
    logic [31:0]        ramaddr_q;
    logic [31:0]        ramstore_q;
    logic [WAIT_W-1:0]  wait_cnt_q;
    logic               timeout_q;
    logic               req_err_q;
    logic [CNT_W-1:0]   ifetch_cnt_q;
    logic [CNT_W-1:0]   dacc_cnt_q;

    logic data_req_s;
    logic grant_data_s;
    logic busy_s;
    logic ack_data_s;
    logic ack_instr_s;
    logic dhit_s;
    logic ihit_s;
    logic expire_s;

    // After a data grant, a pending instruction fetch gets the next slot.
    assign data_req_s   = bus.dREN | bus.dWEN;
    assign grant_data_s = data_req_s & ~(last_data_q & bus.iREN);

    assign busy_s      = (state_q == ST_DATA) | (state_q == ST_INSTR);
    assign ack_data_s  = (state_q == ST_DATA)  & bus.ramACK;
    assign ack_instr_s = (state_q == ST_INSTR) & bus.ramACK;
    // A hit is reported only if the originating request is still asserted.
    assign dhit_s      = ack_data_s & (op_wr_q ? bus.dWEN : bus.dREN);
    assign ihit_s      = ack_instr_s & bus.iREN;
    assign expire_s    = busy_s & ~bus.ramACK & (wait_cnt_q == WAIT_LAST);

    assign bus.dhit       = dhit_s;
    assign bus.ihit       = ihit_s;
    assign bus.dload      = ack_data_s  ? bus.ramload : 32'h0000_0000;
    assign bus.iload      = ack_instr_s ? bus.ramload : 32'h0000_0000;
    assign bus.ramREN     = ram_ren_q;
    assign bus.ramWEN     = ram_wen_q;
    assign bus.ramaddr    = ramaddr_q;
    assign bus.ramstore   = ramstore_q;
    assign bus.timeout    = timeout_q;
    assign bus.req_err    = req_err_q;
    assign bus.ifetch_cnt = ifetch_cnt_q;
    assign bus.dacc_cnt   = dacc_cnt_q;

    // Arbitration FSM, RAM enables, watchdog, flags and counters.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= ST_IDLE;
            last_data_q  <= 1'b0;
            op_wr_q      <= 1'b0;
            ram_ren_q    <= 1'b0;
            ram_wen_q    <= 1'b0;
            ramaddr_q    <= 32'h0000_0000;
            ramstore_q   <= 32'h0000_0000;
            wait_cnt_q   <= '0;
            timeout_q    <= 1'b0;
            req_err_q    <= 1'b0;
            ifetch_cnt_q <= '0;
            dacc_cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_data_s) begin
                        state_q     <= ST_DATA;
                        last_data_q <= 1'b1;
                        op_wr_q     <= bus.dWEN;
                        ram_wen_q   <= bus.dWEN;
                        ram_ren_q   <= ~bus.dWEN;
                        ramaddr_q   <= bus.daddr;
                        ramstore_q  <= bus.dstore;
                        wait_cnt_q  <= '0;
                        if (bus.dREN && bus.dWEN) begin
                            req_err_q <= 1'b1;
                        end else begin
                            req_err_q <= req_err_q;
                        end
                    end else if (bus.iREN) begin
                        state_q     <= ST_INSTR;
                        last_data_q <= 1'b0;
                        op_wr_q     <= 1'b0;
                        ram_ren_q   <= 1'b1;
                        ram_wen_q   <= 1'b0;
                        ramaddr_q   <= bus.iaddr;
                        wait_cnt_q  <= '0;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_DATA, ST_INSTR: begin
                    // ACK on the expiry cycle is a normal completion.
                    if (bus.ramACK || expire_s) begin
                        state_q   <= ST_IDLE;
                        ram_ren_q <= 1'b0;
                        ram_wen_q <= 1'b0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                    end
                    if (expire_s) begin
                        timeout_q <= 1'b1;
                    end else begin
                        timeout_q <= timeout_q;
                    end
                    if (dhit_s) begin
                        dacc_cnt_q <= dacc_cnt_q + CNT_W'(1);
                    end else begin
                        dacc_cnt_q <= dacc_cnt_q;
                    end
                    if (ihit_s) begin
                        ifetch_cnt_q <= ifetch_cnt_q + CNT_W'(1);
                    end else begin
                        ifetch_cnt_q <= ifetch_cnt_q;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    ram_ren_q <= 1'b0;
                    ram_wen_q <= 1'b0;
                end
            endcase
        end
    end
endmodule
